range_rep_checker: RTL and testbench
====================================

Name: range_rep_checker

Overview:
- Synthesisable multi-channel hardware monitor for the temporal check "trigger |-> ##DELAY response[*MIN_REP:MAX_REP]".
- Each channel owns a small FSM that watches a trigger, waits DELAY cycles, then measures the consecutive run length of its response.
- Each channel emits registered pass, fail and drop pulses and keeps saturating event counters.
- Sits beside protocol blocks (e.g. transmitter/receiver pairs) so the check survives into emulation and FPGA builds where SVA is unavailable.

Parameters:
- N_CH, 2, number of independent channels (1..16).
- DELAY, 1, cycles from trigger sample to first response sample (1..255).
- MIN_REP, 2, minimum consecutive high response samples (1..255).
- MAX_REP, 3, maximum consecutive high response samples (MIN_REP..255).
- STRICT, 0, 0 = pass at first match (SVA implication semantics); 1 = run must end within [MIN_REP, MAX_REP].
- CNT_W, 8, width of each saturating event counter.

Ports:
- clk, input, 1, single clock; all sampling on posedge.
- rst, input, 1, asynchronous, active-high reset.
- trig_i, input, N_CH, per-channel trigger (transmitter).
- resp_i, input, N_CH, per-channel response (receiver).
- clr_i, input, 1, synchronous clear of all counters.
- busy_o, output, N_CH, channel attempt in progress.
- pass_o, output, N_CH, one-cycle pass pulse.
- fail_o, output, N_CH, one-cycle fail pulse.
- drop_o, output, N_CH, one-cycle pulse when a trigger is ignored because the channel is busy.
- pass_cnt_o, output, N_CH*CNT_W, per-channel pass count; channel c occupies [c*CNT_W +: CNT_W].
- fail_cnt_o, output, N_CH*CNT_W, per-channel fail count; same packing.
- drop_cnt_o, output, N_CH*CNT_W, per-channel drop count; same packing.

Behaviour:
Reset:
- Asynchronous, active-high. All channels go to IDLE.
- busy_o, pass_o, fail_o, drop_o are 0. All counters are 0.
- Reset asserted mid-attempt aborts the attempt; no pass or fail is produced for it.

Per-channel FSM, states IDLE, WAIT, RUN:
- IDLE: trig_i=1 at edge t -> WAIT with dcnt=DELAY-1. If DELAY=1, go straight to RUN with run=0.
- WAIT: decrement dcnt each edge; at dcnt=0 -> RUN. The first response sample is taken at edge t+DELAY.
- RUN with STRICT=0, at each edge sample resp_i:
  - Sample low with run < MIN_REP -> fail, go to IDLE.
  - Sample high -> run+1; when run reaches MIN_REP -> pass, go to IDLE.
  - MAX_REP is ignored in this mode.
- RUN with STRICT=1, at each edge sample resp_i:
  - Sample low with run < MIN_REP -> fail.
  - Sample low with MIN_REP <= run <= MAX_REP -> pass.
  - Sample high when run = MAX_REP -> fail (overrun).
  - Every decision returns the channel to IDLE.
- The run counter is 8 bits and never exceeds MAX_REP.

Output timing:
- pass_o and fail_o are registered: they are high for exactly the cycle after the deciding edge. Latency from deciding sample to pulse is 1 cycle.
- busy_o is 1 in WAIT and RUN, and 0 in IDLE (including the cycle the result pulse is visible).

Overlap and trigger handling:
- Only one attempt per channel at a time.
- trig_i=1 while in WAIT or RUN: pulse drop_o the next cycle and increment drop_cnt. The current attempt is unaffected.
- trig_i=1 at the same edge an attempt decides: counts as a drop, not a new attempt. The channel needs one IDLE edge before re-arming.
- Channels are fully independent; simultaneous events on different channels are all reported.

Counters:
- Increment in the same cycle the corresponding pulse is visible.
- Saturate at 2^CNT_W-1.
- clr_i=1 zeroes all counters at the edge. Clear takes priority over an increment in the same cycle.
- FSMs are unaffected by clr_i.

Test Plan:
1. N_CH=2, DELAY=1, MIN_REP=2, STRICT=0: trig_i[0]=1 at edge 1, resp_i[0]=1 at edges 2,3 -> pass_o[0]=1 in the cycle after edge 3, pass_cnt ch0=1, ch1 counters 0.
2. Same configuration: trig_i[0] at edge 1, resp_i[0]=0 at edge 2 -> fail_o[0] after edge 2, fail_cnt=1, busy_o[0] drops to 0.
3. STRICT=1, MAX_REP=3, trigger at edge 1:
   - resp high at edges 2,3,4, low at 5 -> pass after edge 5.
   - resp high at edges 2-5 -> fail after edge 5.
   - resp high at edges 2,3, low at 4 -> pass after edge 4.
4. DELAY=3: trig_i[1] at edge 1, second trig_i[1] at edge 2, resp high at edges 4,5 -> drop_o[1] after edge 2, drop_cnt=1, exactly one pass_o[1] after edge 5.
5. rst asserted asynchronously mid-RUN (between edges 3 and 4) -> all outputs 0 immediately, no pass/fail afterwards. A new trigger after release passes normally.
6. CNT_W=4: 17 consecutive passing attempts on ch0 -> pass_cnt saturates at 15. Then clr_i pulse -> 0. clr_i coinciding with a pass pulse -> counter 0.

Source files
------------

// File: rtl/range_rep_checker.sv
// -----------------------------------------------------------------------------
// range_rep_checker
//
// Multi-channel hardware monitor for the temporal check
//   trigger |-> ##DELAY response[*MIN_REP:MAX_REP]
// Each channel arms on its trigger, waits DELAY cycles, then measures the
// consecutive run length of its response and reports pass/fail/drop pulses.
// Every pulse also bumps a saturating per-channel event counter.
//
// Parameters
//   N_CH    : number of independent channels (1..16)
//   DELAY   : cycles from trigger sample to first response sample (1..255)
//   MIN_REP : minimum consecutive high response samples (1..255)
//   MAX_REP : maximum consecutive high response samples (MIN_REP..255)
//   STRICT  : 0 = pass at first match, 1 = run must end inside the window
//   CNT_W   : width of each saturating event counter
//
// Ports
//   clk        : single clock, all sampling on posedge
//   rst        : asynchronous active-high reset
//   trig_i     : per-channel trigger
//   resp_i     : per-channel response
//   clr_i      : synchronous clear of all counters (FSMs unaffected)
//   busy_o     : channel attempt in progress (WAIT or RUN)
//   pass_o     : one-cycle pass pulse
//   fail_o     : one-cycle fail pulse
//   drop_o     : one-cycle pulse when a trigger is ignored (channel busy)
//   pass_cnt_o : per-channel pass count, channel c at [c*CNT_W +: CNT_W]
//   fail_cnt_o : per-channel fail count, same packing
//   drop_cnt_o : per-channel drop count, same packing
// -----------------------------------------------------------------------------
module range_rep_checker #(
  parameter int N_CH    = 2,
  parameter int DELAY   = 1,
  parameter int MIN_REP = 2,
  parameter int MAX_REP = 3,
  parameter int STRICT  = 0,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       trig_i,
  input  logic [N_CH-1:0]       resp_i,
  input  logic                  clr_i,
  output logic [N_CH-1:0]       busy_o,
  output logic [N_CH-1:0]       pass_o,
  output logic [N_CH-1:0]       fail_o,
  output logic [N_CH-1:0]       drop_o,
  output logic [N_CH*CNT_W-1:0] pass_cnt_o,
  output logic [N_CH*CNT_W-1:0] fail_cnt_o,
  output logic [N_CH*CNT_W-1:0] drop_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RUN
  } state_t;

  localparam logic [7:0]       DLY_INIT = 8'(DELAY - 1);
  localparam logic [7:0]       MIN_R    = 8'(MIN_REP);
  localparam logic [7:0]       MAX_R    = 8'(MAX_REP);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Increment-with-saturation shared by all event counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             inc);
    return (inc && (v != CNT_MAX)) ? v + 1'b1 : v;
  endfunction

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_t           state;
    logic [7:0]       dcnt;
    logic [7:0]       run;
    logic             pass_q, fail_q, drop_q;
    logic [CNT_W-1:0] pass_cnt, fail_cnt, drop_cnt;
    logic             pass_hit, fail_hit, drop_hit;

    // Decision for the current edge. The registered pulses and the counters
    // both consume these, so a counter changes in the same cycle its pulse
    // becomes visible.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
      pass_hit = 1'b0;
      fail_hit = 1'b0;
      // A trigger on the deciding edge also lands here: the channel is still
      // in RUN, so it is reported as a drop rather than a new attempt.
      drop_hit = trig_i[c] && (state != S_IDLE);
      if (state == S_RUN) begin
        if (STRICT == 0) begin
          if (resp_i[c]) pass_hit = ((run + 8'd1) == MIN_R);
          else           fail_hit = 1'b1;
        end else begin
          if (resp_i[c])        fail_hit = (run == MAX_R);  // overrun
          else if (run < MIN_R) fail_hit = 1'b1;            // too short
          else                  pass_hit = 1'b1;            // ended in window
        end
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state    <= S_IDLE;
        dcnt     <= '0;
        run      <= '0;
        pass_q   <= 1'b0;
        fail_q   <= 1'b0;
        drop_q   <= 1'b0;
        pass_cnt <= '0;
        fail_cnt <= '0;
        drop_cnt <= '0;
      end else begin
        pass_q <= pass_hit;
        fail_q <= fail_hit;
        drop_q <= drop_hit;

        case (state)
          S_IDLE: begin
            if (trig_i[c]) begin
              run <= '0;
              if (DELAY == 1) begin
                state <= S_RUN;
              end else begin
                state <= S_WAIT;
                dcnt  <= DLY_INIT;
              end
            end
          end
          S_WAIT: begin
            // Leaving on dcnt==1 puts the channel in RUN one edge before the
            // first response sample, which lands at trigger edge + DELAY.
            dcnt <= dcnt - 8'd1;
            if (dcnt == 8'd1) state <= S_RUN;
          end
          S_RUN: begin
            if (pass_hit || fail_hit) begin
              state <= S_IDLE;
              run   <= '0;
            end else if (resp_i[c]) begin
              run <= run + 8'd1;
            end
          end
          default: state <= S_IDLE;
        endcase

        // Clear wins over a same-cycle increment.
        if (clr_i) begin
          pass_cnt <= '0;
          fail_cnt <= '0;
          drop_cnt <= '0;
        end else begin
          pass_cnt <= sat_inc(pass_cnt, pass_hit);
          fail_cnt <= sat_inc(fail_cnt, fail_hit);
          drop_cnt <= sat_inc(drop_cnt, drop_hit);
        end
      end
    end

    assign busy_o[c] = (state != S_IDLE);
    assign pass_o[c] = pass_q;
    assign fail_o[c] = fail_q;
    assign drop_o[c] = drop_q;
    assign pass_cnt_o[c*CNT_W +: CNT_W] = pass_cnt;
    assign fail_cnt_o[c*CNT_W +: CNT_W] = fail_cnt;
    assign drop_cnt_o[c*CNT_W +: CNT_W] = drop_cnt;
  end

endmodule

// File: tb/tb_range_rep_checker.sv
// -----------------------------------------------------------------------------
// tb_range_rep_checker
//
// Directed bench for range_rep_checker. Three instances share clock, reset and
// clear:
//   u_a : DELAY=1, MIN_REP=2, MAX_REP=3, STRICT=0, CNT_W=4
//   u_b : DELAY=1, MIN_REP=2, MAX_REP=3, STRICT=1, CNT_W=8
//   u_c : DELAY=3, MIN_REP=2, MAX_REP=3, STRICT=0, CNT_W=8
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// "Edge k" below counts rising edges from the trigger edge (edge 1).
// -----------------------------------------------------------------------------
module tb_range_rep_checker;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  always #5 clk = ~clk;

  // Instance A
  logic [1:0] trig_a, resp_a, busy_a, pass_a, fail_a, drop_a;
  logic [7:0] pass_cnt_a, fail_cnt_a, drop_cnt_a;
  // Instance B
  logic [1:0]  trig_b, resp_b, busy_b, pass_b, fail_b, drop_b;
  logic [15:0] pass_cnt_b, fail_cnt_b, drop_cnt_b;
  // Instance C
  logic [1:0]  trig_c, resp_c, busy_c, pass_c, fail_c, drop_c;
  logic [15:0] pass_cnt_c, fail_cnt_c, drop_cnt_c;

  range_rep_checker #(.N_CH(2), .DELAY(1), .MIN_REP(2), .MAX_REP(3),
                      .STRICT(0), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .trig_i(trig_a), .resp_i(resp_a), .clr_i(clr),
    .busy_o(busy_a), .pass_o(pass_a), .fail_o(fail_a), .drop_o(drop_a),
    .pass_cnt_o(pass_cnt_a), .fail_cnt_o(fail_cnt_a), .drop_cnt_o(drop_cnt_a)
  );

  range_rep_checker #(.N_CH(2), .DELAY(1), .MIN_REP(2), .MAX_REP(3),
                      .STRICT(1), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .trig_i(trig_b), .resp_i(resp_b), .clr_i(clr),
    .busy_o(busy_b), .pass_o(pass_b), .fail_o(fail_b), .drop_o(drop_b),
    .pass_cnt_o(pass_cnt_b), .fail_cnt_o(fail_cnt_b), .drop_cnt_o(drop_cnt_b)
  );

  range_rep_checker #(.N_CH(2), .DELAY(3), .MIN_REP(2), .MAX_REP(3),
                      .STRICT(0), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .trig_i(trig_c), .resp_i(resp_c), .clr_i(clr),
    .busy_o(busy_c), .pass_o(pass_c), .fail_o(fail_c), .drop_o(drop_c),
    .pass_cnt_o(pass_cnt_c), .fail_cnt_o(fail_cnt_c), .drop_cnt_o(drop_cnt_c)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    trig_a = '0; resp_a = '0;
    trig_b = '0; resp_b = '0;
    trig_c = '0; resp_c = '0;
    cyc(); cyc();

    // ---------------- reset state ----------------
    check("rst_busy",  {busy_a, busy_b, busy_c}, 32'h0);
    check("rst_pulse", {pass_a, fail_a, drop_a, pass_b, fail_b, drop_b,
                        pass_c, fail_c, drop_c}, 32'h0);
    check("rst_cnt_a", {pass_cnt_a, fail_cnt_a, drop_cnt_a}, 32'h0);
    check("rst_cnt_b", {pass_cnt_b, fail_cnt_b}, 32'h0);
    rst = 1'b0;
    cyc();

    // ---------------- 1: STRICT=0 pass on ch0 ----------------
    trig_a = 2'b01;
    cyc();                                   // edge 1
    check("t1_busy", busy_a, 2'b01);
    trig_a = 2'b00; resp_a = 2'b01;
    cyc();                                   // edge 2
    check("t1_nopass_e2", pass_a, 2'b00);
    cyc();                                   // edge 3 decides
    check("t1_pass",      pass_a, 2'b01);
    check("t1_fail",      fail_a, 2'b00);
    check("t1_busy_done", busy_a, 2'b00);
    check("t1_pass_cnt",  pass_cnt_a, 8'h01);
    check("t1_fail_cnt",  fail_cnt_a, 8'h00);
    resp_a = 2'b00;
    cyc();
    check("t1_pass_gone", pass_a, 2'b00);

    // ---------------- 2: STRICT=0 fail on ch0 ----------------
    trig_a = 2'b01;
    cyc();                                   // edge 1
    trig_a = 2'b00; resp_a = 2'b00;
    cyc();                                   // edge 2 low -> fail
    check("t2_fail",     fail_a, 2'b01);
    check("t2_pass",     pass_a, 2'b00);
    check("t2_fail_cnt", fail_cnt_a, 8'h01);
    check("t2_busy",     busy_a, 2'b00);
    cyc();
    check("t2_fail_gone", fail_a, 2'b00);

    // ---------------- 3a: STRICT=1, run of 3 then low -> pass ----------------
    trig_b = 2'b01;
    cyc();                                   // edge 1
    trig_b = 2'b00; resp_b = 2'b01;
    cyc(); cyc(); cyc();                     // edges 2,3,4 high
    check("t3a_busy_e4", busy_b, 2'b01);
    check("t3a_none_e4", {pass_b, fail_b}, 4'h0);
    resp_b = 2'b00;
    cyc();                                   // edge 5 low
    check("t3a_pass",     pass_b, 2'b01);
    check("t3a_fail",     fail_b, 2'b00);
    check("t3a_pass_cnt", pass_cnt_b, 16'h0001);
    cyc();

    // ---------------- 3b: STRICT=1, run of 4 -> overrun fail ----------------
    trig_b = 2'b01;
    cyc();                                   // edge 1
    trig_b = 2'b00; resp_b = 2'b01;
    cyc(); cyc(); cyc();                     // edges 2,3,4
    cyc();                                   // edge 5 high at MAX_REP
    check("t3b_fail",     fail_b, 2'b01);
    check("t3b_pass",     pass_b, 2'b00);
    check("t3b_fail_cnt", fail_cnt_b, 16'h0001);
    resp_b = 2'b00;
    cyc();

    // ------- 3c: STRICT=1, run of 2 then low -> pass; trigger on decide -------
    trig_b = 2'b01;
    cyc();                                   // edge 1
    trig_b = 2'b00; resp_b = 2'b01;
    cyc(); cyc();                            // edges 2,3
    resp_b = 2'b00; trig_b = 2'b01;
    cyc();                                   // edge 4 decides, trigger dropped
    check("t3c_pass",     pass_b, 2'b01);
    check("t3c_pass_cnt", pass_cnt_b, 16'h0002);
    check("t3c_drop",     drop_b, 2'b01);
    check("t3c_drop_cnt", drop_cnt_b, 16'h0001);
    trig_b = 2'b00;
    cyc();
    check("t3c_no_rearm", busy_b, 2'b00);
    check("t3c_quiet",    {pass_b, fail_b, drop_b}, 6'h0);

    // ---------------- 4: DELAY=3, overlapping trigger on ch1 ----------------
    trig_c = 2'b10;
    cyc();                                   // edge 1
    check("t4_busy_e1", busy_c, 2'b10);
    cyc();                                   // edge 2 second trigger
    check("t4_drop",     drop_c, 2'b10);
    check("t4_drop_cnt", drop_cnt_c, 16'h0100);
    trig_c = 2'b00;
    cyc();                                   // edge 3
    check("t4_drop_gone", drop_c, 2'b00);
    check("t4_busy_e3",   busy_c, 2'b10);
    resp_c = 2'b10;
    cyc();                                   // edge 4 first sample
    check("t4_nopass_e4", {pass_c, fail_c}, 4'h0);
    cyc();                                   // edge 5
    check("t4_pass",     pass_c, 2'b10);
    check("t4_pass_cnt", pass_cnt_c, 16'h0100);
    resp_c = 2'b00;
    cyc();
    check("t4_single_pass", {pass_c, fail_c}, 4'h0);
    check("t4_idle",        busy_c, 2'b00);

    // ---------------- 5: asynchronous reset mid-RUN ----------------
    trig_b = 2'b01;
    cyc();                                   // edge 1
    trig_b = 2'b00; resp_b = 2'b01;
    cyc(); cyc();                            // edges 2,3 (run=2, undecided)
    check("t5_busy_pre", busy_b, 2'b01);
    #2 rst = 1'b1;
    #1;
    check("t5_busy_rst",  busy_b, 2'b00);
    check("t5_pulse_rst", {pass_b, fail_b, drop_b}, 6'h0);
    check("t5_cnt_rst",   {pass_cnt_b, fail_cnt_b}, 32'h0);
    cyc();                                   // edge 4 under reset
    rst = 1'b0;
    cyc();                                   // edge 5, resp still high
    check("t5_no_result", {pass_b, fail_b, busy_b}, 6'h0);
    resp_b = 2'b00;
    trig_b = 2'b01;
    cyc();
    trig_b = 2'b00; resp_b = 2'b01;
    cyc(); cyc();
    resp_b = 2'b00;
    cyc();
    check("t5_pass_after", pass_b, 2'b01);
    check("t5_cnt_after",  pass_cnt_b, 16'h0001);

    // ---------------- 6: saturation and clear (CNT_W=4) ----------------
    for (int i = 0; i < 17; i++) begin
      trig_a = 2'b01; resp_a = 2'b00;
      cyc();
      trig_a = 2'b00; resp_a = 2'b01;
      cyc(); cyc();
      if (i == 14) check("t6_cnt_15", pass_cnt_a, 8'h0F);
    end
    resp_a = 2'b00;
    check("t6_saturated", pass_cnt_a, 8'h0F);
    check("t6_fail_zero", fail_cnt_a, 8'h00);
    clr = 1'b1;
    cyc();
    check("t6_clr", pass_cnt_a, 8'h00);
    clr = 1'b0;
    trig_a = 2'b01;
    cyc();
    trig_a = 2'b00; resp_a = 2'b01;
    cyc();
    clr = 1'b1;
    cyc();                                   // deciding edge with clear
    check("t6_clr_pass",     pass_a, 2'b01);
    check("t6_clr_priority", pass_cnt_a, 8'h00);
    clr = 1'b0; resp_a = 2'b00;
    cyc();
    check("t6_after_clr", pass_cnt_a, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
